// File: rtl/negedge_sample_sched_pkg.sv
// Shared types, defaults and the burst-length clamp for negedge_sample_sched.
// Optional abort port is enabled by NEGEDGE_SAMPLE_SCHED_ABORT_EN (see top).
package negedge_sample_sched_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Zero means a full-width burst; anything wider than the word is clamped.
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int unsigned w);
    int unsigned ni;
    ni = 32'(n);
    if (ni == 0 || ni > w) return 4'(w);
    return n;
  endfunction

endpackage

// File: rtl/negedge_sample_sched_dffqn.sv
// Falling-edge D flop with synchronous load enable and true/complement outputs.
// No reset: contents are only consumed after an enabled load.
module dffqn_negedge_en (
  input  logic clk,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qn
);

  always_ff @(negedge clk) begin
    if (en) q <= d;
  end

  assign qn = ~q;

endmodule

// File: rtl/negedge_sample_sched.sv
// Schedules mid-cycle captures of din and assembles a 1..WIDTH bit word, MSB first.
// Define NEGEDGE_SAMPLE_SCHED_ABORT_EN to add an abort input that cancels a running burst.
module negedge_sample_sched
  import negedge_sample_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       start_nbits,
  input  logic [DIV_W-1:0] start_div,
  input  logic             din,
`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             cap_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [3:0]         nbits_q, nbits_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               cap_en_q, cap_en_d;
  logic               cap_q;
  logic               cap_qn_unused;
  logic               abort_w;

`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  dffqn_negedge_en u_cap (
    .clk (clk),
    .en  (cap_en_q),
    .d   (din),
    .q   (cap_q),
    .qn  (cap_qn_unused)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    nbits_d  = nbits_q;
    shift_d  = shift_q;
    cap_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          nbits_d  = clamp_nbits(start_nbits, WIDTH);
          cnt_d    = start_div;
          div_d    = start_div;
          bitcnt_d = 4'd0;
          shift_d  = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cap_en_d = 1'b1;
          state_d  = CAPT;
        end
      end
      CAPT: begin
        // cap_q was loaded at this cycle's falling edge.
        shift_d  = {shift_q[WIDTH-2:0], cap_q};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == nbits_q - 4'd1) begin
          state_d = DONE;
        end else begin
          cnt_d   = div_q;
          state_d = WAIT;
        end
      end
      DONE: begin
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w && (state_q == WAIT || state_q == CAPT)) begin
      state_d  = IDLE;
      cap_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bitcnt_q <= 4'd0;
      nbits_q  <= 4'd0;
      shift_q  <= '0;
      cap_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      nbits_q  <= nbits_d;
      shift_q  <= shift_d;
      cap_en_q <= cap_en_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == WAIT) || (state_q == CAPT);
  assign cap_en      = cap_en_q;
  assign dout_valid  = (state_q == DONE);
  assign dout        = shift_q;

endmodule

// File: tb/tb_negedge_sample_sched.sv
// Directed bench for negedge_sample_sched with a scoreboard of expected words.
module tb_negedge_sample_sched;

  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [3:0]    start_nbits = 4'd0;
  logic [DW-1:0] start_div = '0;
  logic          din = 1'b0;
`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy;
  logic          cap_en;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  negedge_sample_sched #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_nbits (start_nbits),
    .start_div   (start_div),
    .din         (din),
`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .cap_en      (cap_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst: pat holds the bits to present, oldest in bit neff-1.
  task automatic burst(input logic [3:0] nb, input logic [7:0] dv, input logic [15:0] pat,
                       input int neff, input bit glitch, input int hold);
    logic [15:0]  mask;
    logic [W-1:0] expv;
    logic [W-1:0] got;
    int k, cyc, pulses, dbl;
    logic prev, b;
    mask = (16'd1 << neff) - 16'd1;
    expv = W'(pat & mask);
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    start_nbits = nb;
    start_div   = dv;
    tick();
    start_valid = 1'b0;
    exp_q.push_back(expv);
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0; cyc = 0; pulses = 0; dbl = 0; prev = 1'b0;
    while (dout_valid !== 1'b1 && cyc < 600) begin
      if (cap_en === 1'b1) begin
        pulses++;
        if (prev) dbl++;
        b = (k < neff) ? pat[neff-1-k] : 1'b0;
        k++;
        if (glitch) begin
          din = ~b;
          #1 din = b;
          @(negedge clk);
          #1 din = ~b;
        end else begin
          din = b;
        end
      end else begin
        din = 1'($urandom);
      end
      prev = cap_en;
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(neff * (32'(dv) + 2)));
    check("cap_pulses", 32'(pulses), 32'(neff));
    check("cap_double", 32'(dbl), 32'd0);
    got = exp_q.pop_front();
    if (dout_valid === 1'b1) check("dout", 32'(dout), 32'(got));
    else check("dout_valid_timeout", 32'(dout_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      start_valid = (i == 3);
      tick();
      check("hold_dout", 32'(dout), 32'(expv));
      check("hold_valid", 32'(dout_valid), 32'd1);
      check("hold_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("valid_drop", 32'(dout_valid), 32'd0);
    check("idle_after_accept", 32'(start_ready), 32'd1);
    tick();
    check("no_queued_start", 32'(busy), 32'd0);
  endtask

  task automatic abort_mid(input bit use_abort);
    int cyc, pulses, seen;
    start_valid = 1'b1;
    start_nbits = 4'd8;
    start_div   = 8'd1;
    tick();
    start_valid = 1'b0;
    cyc = 0; pulses = 0;
    while (pulses < 3 && cyc < 200) begin
      if (cap_en === 1'b1) pulses++;
      din = 1'($urandom);
      tick();
      cyc++;
    end
    check("reach_3_bits", 32'(pulses), 32'd3);
`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
    if (use_abort) abort = 1'b1; else rst = 1'b1;
    tick();
    abort = 1'b0;
    rst   = 1'b0;
`else
    if (!use_abort) rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    check("cancel_start_ready", 32'(start_ready), 32'd1);
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_cap_en", 32'(cap_en), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dout_valid !== 1'b0) seen++;
      tick();
    end
    check("cancel_no_valid", 32'(seen), 32'd0);
    burst(4'd2, 8'd0, 16'b10, 2, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_cap_en", 32'(cap_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();

    burst(4'd8,  8'd0, 16'hB2,    8, 1'b0, 0);
    burst(4'd3,  8'd4, 16'b110,   3, 1'b0, 0);
    burst(4'd0,  8'd1, 16'h5C,    8, 1'b0, 0);
    burst(4'd12, 8'd0, 16'hA7,    8, 1'b0, 10);
    burst(4'd5,  8'd2, 16'b10110, 5, 1'b1, 0);
    burst(4'd8,  8'd0, 16'h3C,    8, 1'b1, 0);

    abort_mid(1'b0);
`ifdef NEGEDGE_SAMPLE_SCHED_ABORT_EN
    abort_mid(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
